// File: rtl/ac_datapath.sv
// ac_datapath: register file + accumulator + ALU behind a valid/ready micro-op port.
// Optional shift-add multiplier (opcode 13) is built when AC_DATAPATH_MUL_EN is defined;
// without it opcode 13 is rejected as illegal and the block is always ready.
module ac_datapath #(
    parameter  int WIDTH = 16,
    parameter  int NREG  = 8,
    localparam int RAW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [RAW-1:0]   cmd_reg,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    output logic             z,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDR  = 4'd1;
    localparam logic [3:0] OP_LDAC = 4'd2;
    localparam logic [3:0] OP_STAC = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_INC  = 4'd9;
    localparam logic [3:0] OP_CLR  = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;
    localparam logic [3:0] OP_SHR  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    localparam logic [RAW:0] NREG_W = NREG[RAW:0];

    logic [WIDTH-1:0] ac_q, ac_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] reg_q [NREG];
    logic [WIDTH-1:0] reg_d [NREG];

    logic             accept;
    logic             uses_reg;
    logic             reg_ok;
    logic             op_known;
    logic             op_legal;
    logic             ac_wr;
    logic [WIDTH-1:0] rd;
    logic [WIDTH:0]   sum;

`ifdef AC_DATAPATH_MUL_EN
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] partial;

    assign busy = (state_q == S_MUL);
`else
    assign busy = 1'b0;
`endif

    assign cmd_ready = !busy;
    assign accept    = cmd_valid && cmd_ready;
    assign dataout   = ac_q;
    assign z         = z_q;
    assign c         = c_q;
    assign done      = done_q;
    assign illegal   = illegal_q;

    // Decode legality: unknown opcodes and out-of-range register operands are rejected.
    always_comb begin
        uses_reg = ((cmd_op >= OP_LDR) && (cmd_op <= OP_XOR)) || (cmd_op == OP_MUL);
        reg_ok   = ({1'b0, cmd_reg} < NREG_W);
        op_known = (cmd_op <= OP_SHR);
`ifdef AC_DATAPATH_MUL_EN
        if (cmd_op == OP_MUL) op_known = 1'b1;
`endif
        op_legal = op_known && (!uses_reg || reg_ok);
        rd       = reg_ok ? reg_q[cmd_reg] : '0;
        sum      = {1'b0, ac_q} + {1'b0, rd};
    end

    // Next-state: single-cycle ALU ops at accept, multiplier sequencing while busy.
    always_comb begin
        ac_d      = ac_q;
        z_d       = z_q;
        c_d       = c_q;
        reg_d     = reg_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        ac_wr     = 1'b0;
`ifdef AC_DATAPATH_MUL_EN
        state_d  = state_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        partial  = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif
        if (accept) begin
            done_d = 1'b1;
            if (!op_legal) begin
                illegal_d = 1'b1;
            end else begin
                case (cmd_op)
                    OP_LDR:  reg_d[cmd_reg] = datain;
                    OP_LDAC: begin ac_d = rd;          ac_wr = 1'b1; end
                    OP_STAC: reg_d[cmd_reg] = ac_q;
                    OP_ADD:  begin ac_d = sum[WIDTH-1:0]; c_d = sum[WIDTH]; ac_wr = 1'b1; end
                    OP_SUB:  begin ac_d = ac_q - rd;   c_d = (ac_q < rd); ac_wr = 1'b1; end
                    OP_AND:  begin ac_d = ac_q & rd;   ac_wr = 1'b1; end
                    OP_OR:   begin ac_d = ac_q | rd;   ac_wr = 1'b1; end
                    OP_XOR:  begin ac_d = ac_q ^ rd;   ac_wr = 1'b1; end
                    OP_INC:  begin ac_d = ac_q + 1'b1; ac_wr = 1'b1; end
                    OP_CLR:  begin ac_d = '0;          ac_wr = 1'b1; end
                    OP_SHL:  begin ac_d = ac_q << 1;   c_d = ac_q[WIDTH-1]; ac_wr = 1'b1; end
                    OP_SHR:  begin ac_d = ac_q >> 1;   c_d = ac_q[0];       ac_wr = 1'b1; end
`ifdef AC_DATAPATH_MUL_EN
                    OP_MUL: begin
                        // Snapshot operands; done is deferred to the final step.
                        done_d   = 1'b0;
                        state_d  = S_MUL;
                        mplier_d = ac_q;
                        mcand_d  = rd;
                        prod_d   = '0;
                        cnt_d    = '0;
                    end
`endif
                    default: ;
                endcase
            end
        end
`ifdef AC_DATAPATH_MUL_EN
        if (state_q == S_MUL) begin
            // One multiplier bit per cycle; only the low WIDTH product bits are kept.
            prod_d   = partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                ac_d    = partial;
                ac_wr   = 1'b1;
                c_d     = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
`endif
        if (ac_wr) z_d = (ac_d == '0);
    end

    // State registers; reset also aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ac_q      <= '0;
            z_q       <= 1'b1;
            c_q       <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
`ifdef AC_DATAPATH_MUL_EN
            state_q  <= S_IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            ac_q      <= ac_d;
            z_q       <= z_d;
            c_q       <= c_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            reg_q     <= reg_d;
`ifdef AC_DATAPATH_MUL_EN
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule
